// File: rtl/seg7_pkg.sv
// Shared segment encoding for the seven-segment scan driver.
// Bit layout is {dp,g,f,e,d,c,b,a}, active-high before pin polarity.
package seg7_pkg;

  typedef logic [7:0] seg7_code_t;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam seg7_code_t SEG7_DP_MASK = 8'h80;

  // Hex glyphs 0..F; the dp bit is always clear here and filled in per digit.
  localparam seg7_code_t SEG7_TABLE [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic seg7_code_t seg7_lookup(input logic [3:0] nibble,
                                             input logic       dp_bit);
    seg7_code_t code;
    code         = SEG7_TABLE[nibble];
    code[SEG_DP] = dp_bit;
    return code;
  endfunction

endpackage

// File: rtl/seg7_hex_encode.sv
// Combinational nibble-to-segment lookup with the decimal point merged in.
module seg7_hex_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output seg7_code_t code_o
);

  assign code_o = seg7_lookup(nibble_i, dp_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for DIGITS seven-segment displays with frame-synchronous load.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PC_W  = $clog2(REFRESH_DIV);

  localparam logic [PC_W-1:0]   PC_LAST  = PC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                : {DIGITS{1'b0}};

  logic [PC_W-1:0]     pcnt_q, pcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                fs_q, fs_d;

  logic                slot_wrap;
  logic                frame_wrap;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lzb;
  seg7_code_t          enc_code;
  seg7_code_t          seg_raw;
  logic [DIGITS-1:0]   an_onehot;
  logic [7:0]          seg_vis;
  logic [DIGITS-1:0]   an_vis;

  // Scan counters: pcnt runs through one digit slot, idx walks the digits.
  always_comb begin
    slot_wrap  = (pcnt_q == PC_LAST);
    frame_wrap = slot_wrap && (idx_q == IDX_LAST);
    pcnt_d     = slot_wrap ? '0 : pcnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Load handshake: load is a one-cycle valid with no ready; every pulse is
  // taken into pend (last write wins) and reaches disp only at a frame wrap.
  // A load on the wrap cycle refills pend while disp takes the older pend.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    if (frame_wrap && pend_valid_q) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
    end
    if (frame_wrap) begin
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp;
      pend_valid_d = 1'b1;
    end
  end

  assign cur_nib = disp_val_q[{idx_q, 2'b00} +: 4];
  assign cur_dp  = disp_dp_q[idx_q];

`ifdef SEG7_LZB_EN
  logic [DIGITS-1:0] lzb_mask;
  logic              lead_zero;

  // Walk down from the top digit; the mask stays set while nibbles are zero.
  always_comb begin
    lzb_mask  = '0;
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (disp_val_q[4*i +: 4] != 4'h0) begin
        lead_zero = 1'b0;
      end
      lzb_mask[i] = lead_zero;
    end
  end

  assign cur_lzb = lzb_mask[idx_q];
`else
  assign cur_lzb = 1'b0;
`endif

  seg7_hex_encode u_enc (
    .nibble_i (cur_nib),
    .dp_i     (cur_dp),
    .code_o   (enc_code)
  );

  // Output stage: an stays dark on the first cycle of each slot to avoid ghosting.
  always_comb begin
    seg_raw   = cur_lzb ? (enc_code & SEG7_DP_MASK) : enc_code;
    an_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
    seg_vis   = blank ? 8'h00 : seg_raw;
    an_vis    = (blank || (pcnt_q == '0)) ? {DIGITS{1'b0}} : an_onehot;
    seg_d     = seg_vis ^ SEG_OFF;
    an_d      = an_vis ^ AN_OFF;
    fs_d      = (pcnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      fs_q         <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      fs_q         <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: an active-high and an active-low instance
// share stimulus; expected segment codes are written out per frame.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blank;
  logic [7:0]  seg_h, seg_l;
  logic [3:0]  an_h, an_l;
  logic        fs_h, fs_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .blank(blank),
    .seg(seg_h), .an(an_h), .frame_start(fs_h)
  );

  seg7_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut_n (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .blank(blank),
    .seg(seg_l), .an(an_l), .frame_start(fs_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!fs_h && k < 40);
    check("frame_wait", {31'b0, fs_h}, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Checks one whole frame starting at the next frame_start; e0..e3 are
  // the active-high segment codes expected on digits 0..3.
  task automatic scan_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    logic [3:0] exp_an, exp_an_n;
    logic [7:0] exp_seg_n;
    int d, p;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    wait_frame();
    for (int n = 0; n < 16; n++) begin
      if (n > 0) @(negedge clk);
      d         = n / 4;
      p         = n % 4;
      exp_an    = (p == 0) ? 4'b0000 : (4'b0001 << d);
      exp_an_n  = ~exp_an;
      exp_seg_n = ~e[d];
      check($sformatf("%s_an_%0d", name, n), an_h, exp_an);
      check($sformatf("%s_seg_%0d", name, n), seg_h, e[d]);
      check($sformatf("%s_fs_%0d", name, n), fs_h, (n == 0));
      check($sformatf("%s_an_n_%0d", name, n), an_l, exp_an_n);
      check($sformatf("%s_seg_n_%0d", name, n), seg_l, exp_seg_n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; value = '0; dp = '0; load = 1'b0; blank = 1'b0;
    step(2);
    check("rst_seg", seg_h, 8'h00);
    check("rst_an", an_h, 4'h0);
    check("rst_fs", fs_h, 1'b0);
    check("rst_seg_n", seg_l, 8'hFF);
    check("rst_an_n", an_l, 4'hF);
    rst = 1'b0;

    // First frame after reset shows 0x0000.
    wait_frame();
    check("boot_seg", seg_h, 8'h3F);
    check("boot_an", an_h, 4'h0);

    // Scan order with dp on digit 0.
    do_load(16'h1234, 4'b0001);
    scan_frame("scan1234", 8'hE6, 8'h4F, 8'h5B, 8'h06);

    // Load while idx=1: old value holds until the next frame.
    wait_frame();
    step(5);
    check("mid_an_idx1", an_h, 4'b0010);
    do_load(16'hABCD, 4'b0000);
    check("hold_d1", seg_h, 8'h4F);
    step(2);
    check("hold_d2", seg_h, 8'h5B);
    step(4);
    check("hold_d3", seg_h, 8'h06);
    scan_frame("scanABCD", 8'h5E, 8'h39, 8'h7C, 8'h77);

    // Two loads in one frame: only the last is shown.
    do_load(16'h1111, 4'b0000);
    check("still_abcd", seg_h, 8'h5E);
    do_load(16'h2222, 4'b0000);
    scan_frame("scan2222", 8'h5B, 8'h5B, 8'h5B, 8'h5B);

    // Load on the wrap cycle goes one frame after the pending one.
    do_load(16'h5678, 4'b0000);
    step(14);
    do_load(16'h9999, 4'b0000);
    scan_frame("scan5678", 8'h7F, 8'h07, 8'h7D, 8'h6D);
    scan_frame("scan9999", 8'h6F, 8'h6F, 8'h6F, 8'h6F);

    // Reset in the middle of a frame.
    do_load(16'h1234, 4'b0000);
    scan_frame("scan1234b", 8'h66, 8'h4F, 8'h5B, 8'h06);
    wait_frame();
    step(9);
    check("pre_rst_an", an_h, 4'b0100);
    rst = 1'b1;
    #1;
    check("mrst_seg", seg_h, 8'h00);
    check("mrst_an", an_h, 4'h0);
    check("mrst_fs", fs_h, 1'b0);
    check("mrst_seg_n", seg_l, 8'hFF);
    check("mrst_an_n", an_l, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    wait_frame();
    check("post_rst_seg", seg_h, 8'h3F);
    check("post_rst_an", an_h, 4'h0);
    step(1);
    check("post_rst_an1", an_h, 4'b0001);
    check("post_rst_seg1", seg_h, 8'h3F);

    // Blank: dark on both polarities, scanning and loads continue.
    blank = 1'b1;
    step(1);
    check("blank_seg", seg_h, 8'h00);
    check("blank_an", an_h, 4'h0);
    check("blank_seg_n", seg_l, 8'hFF);
    check("blank_an_n", an_l, 4'hF);
    do_load(16'h0050, 4'b1000);
    check("blank_seg_b", seg_h, 8'h00);
    check("blank_an_n_b", an_l, 4'hF);
    step(3);
    blank = 1'b0;
    step(1);
    check("unblank_an", an_h, 4'b0010);
    check("unblank_seg", seg_h, 8'h3F);
    check("unblank_an_n", an_l, 4'b1101);
    check("unblank_seg_n", seg_l, 8'hC0);
    step(9);
    check("phase_fs", fs_h, 1'b1);

`ifdef SEG7_LZB_EN
    scan_frame("lzb0050", 8'h3F, 8'h6D, 8'h00, 8'h80);
    do_load(16'h0000, 4'b0000);
    scan_frame("lzb0000", 8'h3F, 8'h00, 8'h00, 8'h00);
`else
    scan_frame("full0050", 8'h3F, 8'h6D, 8'h3F, 8'hBF);
    do_load(16'h0000, 4'b0000);
    scan_frame("full0000", 8'h3F, 8'h3F, 8'h3F, 8'h3F);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
